// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: buffers register writes in a DEPTH-entry FIFO and issues one registered strobe per cycle.
// Accept at edge N is issued at edge N+1; req_ready drops only while the FIFO is full.
module regfile_wb_ctrl #(
    parameter int DATA_W = 4,
    parameter int NREG   = 4,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              hold,
    input  logic              flush,
    input  logic              err_clr,
    output logic [NREG-1:0]   chosen,
    output logic              w_en,
    output logic [DATA_W-1:0] w_data,
    output logic              busy,
    output logic              err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + DATA_W;
    // Saturate the legal-address limit so a bank larger than the address space never wraps.
    localparam int NREG_SAT = (NREG >= (2 ** ADDR_W)) ? (2 ** ADDR_W) : NREG;
    localparam logic [ADDR_W:0] NREG_LIM = (ADDR_W + 1)'(NREG_SAT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STALL
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [EW-1:0]     mem [DEPTH];
    logic              accept;
    logic              legal;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign req_ready = (count < CW'(DEPTH));
    assign legal     = ({1'b0, req_addr} < NREG_LIM);
    assign accept    = req_valid && req_ready && !flush;
    assign push      = accept && legal;
    assign pop       = (state != IDLE) && !hold && !flush;
    assign {head_addr, head_data} = mem[rd_ptr];
    assign busy      = (count != '0) || w_en;

    // state mirrors occupancy: IDLE exactly when the FIFO is empty.
    always_comb begin
        count_nxt = count;
        state_nxt = state;
        if (flush) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + CW'(push) - CW'(pop);
        end
        if (count_nxt == '0) begin
            state_nxt = IDLE;
        end else if (hold) begin
            state_nxt = STALL;
        end else begin
            state_nxt = ISSUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {req_addr, req_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_en   <= 1'b0;
            chosen <= '0;
            w_data <= '0;
        end else if (pop) begin
            w_en   <= 1'b1;
            chosen <= NREG'(1) << head_addr;
            w_data <= head_data;
        end else begin
            w_en   <= 1'b0;
            chosen <= '0;
        end
    end

    // An illegal accept in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept && !legal) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios then random traffic, checked against a queue-based reference model.
module tb_regfile_wb_ctrl;

    localparam int DATA_W = 4;
    localparam int NREG   = 4;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              hold;
    logic              flush;
    logic              err_clr;
    logic [NREG-1:0]   chosen;
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic              busy;
    logic              err;

    regfile_wb_ctrl #(
        .DATA_W(DATA_W),
        .NREG  (NREG),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_data (req_data),
        .hold     (hold),
        .flush    (flush),
        .err_clr  (err_clr),
        .chosen   (chosen),
        .w_en     (w_en),
        .w_data   (w_data),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } item_t;

    item_t             q[$];
    logic              m_err;
    logic              m_wen;
    logic [NREG-1:0]   m_chosen;
    logic [DATA_W-1:0] m_wdata;
    int                total;
    int                bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".w_en"},      32'(w_en),      32'(m_wen));
        check({tag, ".chosen"},    32'(chosen),    32'(m_chosen));
        check({tag, ".w_data"},    32'(w_data),    32'(m_wdata));
        check({tag, ".err"},       32'(err),       32'(m_err));
        check({tag, ".busy"},      32'(busy),      32'((q.size() != 0) || m_wen));
        check({tag, ".req_ready"}, 32'(req_ready), 32'(q.size() < DEPTH));
    endtask

    task automatic model_reset();
        q.delete();
        m_err    = 1'b0;
        m_wen    = 1'b0;
        m_chosen = '0;
        m_wdata  = '0;
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic h, input logic f, input logic c);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        hold      = h;
        flush     = f;
        err_clr   = c;
    endtask

    // Advance one clock edge, apply the write-back rules to the model, then compare.
    task automatic step(input string tag);
        bit                acc;
        bit                do_pop;
        bit                f;
        bit                c;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        item_t             it;
        acc    = req_valid && (q.size() < DEPTH) && !flush;
        do_pop = (q.size() > 0) && !hold && !flush;
        f      = flush;
        c      = err_clr;
        a      = req_addr;
        d      = req_data;
        @(posedge clk);
        #1;
        if (f) q.delete();
        if (do_pop) begin
            it       = q.pop_front();
            m_wen    = 1'b1;
            m_chosen = NREG'(1 << it.a);
            m_wdata  = it.d;
        end else begin
            m_wen    = 1'b0;
            m_chosen = '0;
        end
        if (acc && a < NREG) q.push_back('{a: a, d: d});
        if (acc && a >= NREG) m_err = 1'b1;
        else if (c) m_err = 1'b0;
        check_all(tag);
    endtask

    logic [ADDR_W-1:0] bb_a [4];
    logic [DATA_W-1:0] bb_d [4];
    logic [NREG-1:0]   bb_c [4];

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;

        // single write
        drive(1, 2, 4'hA, 0, 0, 0);
        step("single.acc");
        drive(0, 0, 0, 0, 0, 0);
        step("single.n1");
        check("single.n1.w_en", 32'(w_en), 32'd1);
        check("single.n1.chosen", 32'(chosen), 32'b0100);
        check("single.n1.w_data", 32'(w_data), 32'hA);
        step("single.n2");
        check("single.n2.w_en", 32'(w_en), 32'd0);
        check("single.n2.chosen", 32'(chosen), 32'd0);
        check("single.n2.w_data", 32'(w_data), 32'hA);

        // back-to-back writes
        bb_a = '{3'd0, 3'd1, 3'd3, 3'd0};
        bb_d = '{4'h3, 4'h5, 4'hF, 4'h9};
        bb_c = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            drive(1, bb_a[i], bb_d[i], 0, 0, 0);
            step("b2b");
            check("b2b.req_ready", 32'(req_ready), 32'd1);
            if (i > 0) check("b2b.chosen_seq", 32'(chosen), 32'(bb_c[i-1]));
        end
        drive(0, 0, 0, 0, 0, 0);
        step("b2b.tail");
        check("b2b.chosen_last", 32'(chosen), 32'(bb_c[3]));
        check("b2b.w_data_last", 32'(w_data), 32'h9);
        step("b2b.idle");

        // stall to full, then release
        drive(1, 1, 4'h7, 1, 0, 0);
        step("stall.a1");
        check("stall.a1.req_ready", 32'(req_ready), 32'd1);
        drive(1, 2, 4'h8, 1, 0, 0);
        step("stall.a2");
        check("stall.full.req_ready", 32'(req_ready), 32'd0);
        drive(1, 3, 4'h9, 1, 0, 0);
        step("stall.blk1");
        step("stall.blk2");
        check("stall.blk2.w_en", 32'(w_en), 32'd0);
        drive(1, 3, 4'h9, 0, 0, 0);
        step("stall.pop1");
        check("stall.pop1.chosen", 32'(chosen), 32'b0010);
        check("stall.pop1.req_ready", 32'(req_ready), 32'd1);
        step("stall.pop2");
        check("stall.pop2.chosen", 32'(chosen), 32'b0100);
        drive(0, 0, 0, 0, 0, 0);
        step("stall.pop3");
        check("stall.pop3.chosen", 32'(chosen), 32'b1000);
        check("stall.pop3.w_data", 32'(w_data), 32'h9);
        step("stall.idle");

        // illegal address and sticky error
        drive(1, 5, 4'h1, 0, 0, 0);
        step("ill.acc");
        step("ill.after");
        check("ill.err", 32'(err), 32'd1);
        check("ill.w_en", 32'(w_en), 32'd0);
        drive(1, 6, 4'h2, 0, 0, 1);
        step("ill.setwins");
        check("ill.setwins.err", 32'(err), 32'd1);
        drive(0, 0, 0, 0, 0, 1);
        step("ill.clr");
        check("ill.clr.err", 32'(err), 32'd0);

        // flush with two pending plus a simultaneous request; err preset to 1
        drive(1, 7, 4'h0, 1, 0, 0);
        step("flush.seterr");
        drive(1, 0, 4'h1, 1, 0, 0);
        step("flush.p1");
        drive(1, 1, 4'h2, 1, 0, 0);
        step("flush.p2");
        drive(1, 2, 4'h3, 0, 1, 0);
        step("flush.edge");
        check("flush.busy", 32'(busy), 32'd0);
        check("flush.err", 32'(err), 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        step("flush.n1");
        check("flush.n1.w_en", 32'(w_en), 32'd0);
        step("flush.n2");

        // asynchronous reset mid-cycle with two entries pending and err set
        drive(1, 7, 4'h0, 1, 0, 0);
        step("rst.seterr");
        drive(1, 0, 4'h4, 1, 0, 0);
        step("rst.p1");
        drive(1, 3, 4'h5, 1, 0, 0);
        step("rst.p2");
        drive(0, 0, 0, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst.mid");
        check("rst.mid.w_data", 32'(w_data), 32'd0);
        #1;
        rst = 1'b0;
        step("rst.after");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0));
            step("rand");
        end
        drive(0, 0, 0, 0, 0, 0);
        step("drain1");
        step("drain2");
        step("drain3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
